// File: rtl/alu_pkg.sv
// Shared ALU control codes, MIPS opcode/funct constants and the decode record
// passed from the instruction decoder to the issue stage.
package alu_pkg;

    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_SUBNE   = 4'b0011;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_SLT     = 4'b0111;
    localparam logic [3:0] CTRL_NOR     = 4'b1000;
    localparam logic [3:0] CTRL_XOR     = 4'b1001;
    localparam logic [3:0] CTRL_SLL     = 4'b1010;
    localparam logic [3:0] CTRL_SRA     = 4'b1011;
    localparam logic [3:0] CTRL_SRL     = 4'b1100;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        SEL0_RS      = 2'd0,
        SEL0_SHAMT   = 2'd1,
        SEL0_SIXTEEN = 2'd2
    } sel0_e;

    typedef enum logic {
        SEL1_RT  = 1'b0,
        SEL1_IMM = 1'b1
    } sel1_e;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_e;

    typedef struct packed {
        logic [3:0] ctrl;
        sel0_e      sel0;
        sel1_e      sel1;
        ext_e       ext;
        logic       reg_write;
        logic       is_branch;
        logic       illegal;
    } decode_t;

    function automatic decode_t dec_r(input logic [3:0] ctrl, input sel0_e sel0);
        decode_t d;
        d = '{ctrl: ctrl, sel0: sel0, sel1: SEL1_RT, ext: EXT_ZERO,
              reg_write: 1'b1, is_branch: 1'b0, illegal: 1'b0};
        return d;
    endfunction

    function automatic decode_t dec_i(input logic [3:0] ctrl, input sel0_e sel0,
                                      input sel1_e sel1, input ext_e ext,
                                      input logic reg_write, input logic is_branch);
        decode_t d;
        d = '{ctrl: ctrl, sel0: sel0, sel1: sel1, ext: ext,
              reg_write: reg_write, is_branch: is_branch, illegal: 1'b0};
        return d;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS opcode/funct decoder producing the ALU control record.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = CTRL_ILLEGAL
) (
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output decode_t    dec_o
);

    // Anything not matched below stays illegal: ILLEGAL_CTRL, no write, no branch.
    always_comb begin
        dec_o = '{ctrl: ILLEGAL_CTRL, sel0: SEL0_RS, sel1: SEL1_RT, ext: EXT_ZERO,
                  reg_write: 1'b0, is_branch: 1'b0, illegal: 1'b1};
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_AND:           dec_o = dec_r(CTRL_AND, SEL0_RS);
                    FN_OR:            dec_o = dec_r(CTRL_OR,  SEL0_RS);
                    FN_ADD, FN_ADDU:  dec_o = dec_r(CTRL_ADD, SEL0_RS);
                    FN_SUB, FN_SUBU:  dec_o = dec_r(CTRL_SUB, SEL0_RS);
                    FN_SLT:           dec_o = dec_r(CTRL_SLT, SEL0_RS);
                    FN_NOR:           dec_o = dec_r(CTRL_NOR, SEL0_RS);
                    FN_XOR:           dec_o = dec_r(CTRL_XOR, SEL0_RS);
                    FN_SLL:           dec_o = dec_r(CTRL_SLL, SEL0_SHAMT);
                    FN_SRA:           dec_o = dec_r(CTRL_SRA, SEL0_SHAMT);
                    FN_SRL:           dec_o = dec_r(CTRL_SRL, SEL0_SHAMT);
                    FN_SLLV:          dec_o = dec_r(CTRL_SLL, SEL0_RS);
                    FN_SRAV:          dec_o = dec_r(CTRL_SRA, SEL0_RS);
                    FN_SRLV:          dec_o = dec_r(CTRL_SRL, SEL0_RS);
                    default:          ;
                endcase
            end
            OP_ADDI, OP_ADDIU: dec_o = dec_i(CTRL_ADD, SEL0_RS, SEL1_IMM, EXT_SIGN, 1'b1, 1'b0);
            OP_SLTI:  dec_o = dec_i(CTRL_SLT,   SEL0_RS,      SEL1_IMM, EXT_SIGN, 1'b1, 1'b0);
            OP_ANDI:  dec_o = dec_i(CTRL_AND,   SEL0_RS,      SEL1_IMM, EXT_ZERO, 1'b1, 1'b0);
            OP_ORI:   dec_o = dec_i(CTRL_OR,    SEL0_RS,      SEL1_IMM, EXT_ZERO, 1'b1, 1'b0);
            OP_XORI:  dec_o = dec_i(CTRL_XOR,   SEL0_RS,      SEL1_IMM, EXT_ZERO, 1'b1, 1'b0);
            OP_LUI:   dec_o = dec_i(CTRL_SLL,   SEL0_SIXTEEN, SEL1_IMM, EXT_ZERO, 1'b1, 1'b0);
            OP_LW:    dec_o = dec_i(CTRL_ADD,   SEL0_RS,      SEL1_IMM, EXT_SIGN, 1'b1, 1'b0);
            OP_SW:    dec_o = dec_i(CTRL_ADD,   SEL0_RS,      SEL1_IMM, EXT_SIGN, 1'b0, 1'b0);
            // bne uses a bit2=0 code so the ALU Zero flag reads "not equal".
            OP_BEQ:   dec_o = dec_i(CTRL_SUB,   SEL0_RS,      SEL1_RT,  EXT_ZERO, 1'b0, 1'b1);
            OP_BNE:   dec_o = dec_i(CTRL_SUBNE, SEL0_RS,      SEL1_RT,  EXT_ZERO, 1'b0, 1'b1);
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes into registered ALU ctrl/operands, handles
// stall/flush and resolves beq/bne from the ALU Zero flag in EX.
module alu_issue
    import alu_pkg::*;
#(
    parameter int         DATA_W       = 32,
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_in_0,
    output logic [DATA_W-1:0] alu_in_1,
    input  logic              alu_zero,
    output logic              ex_valid,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_illegal,
    output logic              branch_taken,
    output logic [31:0]       branch_target
);

    decode_t           dec_s;
    logic [5:0]        opcode_s;
    logic [4:0]        rt_f_s, rd_f_s, shamt_s;
    logic [15:0]       imm_s;
    logic              unused_rs_s;
    logic [DATA_W-1:0] imm_ext_s, in0_d, in1_d;
    logic [4:0]        rd_d;
    logic              load_s, valid_d, wr_d, ill_d, br_d;
    logic [31:0]       tgt_d;

    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] in0_q, in1_q;
    logic [4:0]        rd_q;
    logic              valid_q, wr_q, ill_q, br_q;
    logic [31:0]       tgt_q;

    assign opcode_s    = id_instr[31:26];
    assign rt_f_s      = id_instr[20:16];
    assign rd_f_s      = id_instr[15:11];
    assign shamt_s     = id_instr[10:6];
    assign imm_s       = id_instr[15:0];
    assign unused_rs_s = ^id_instr[25:21];

    alu_ctrl_decode #(.ILLEGAL_CTRL(ILLEGAL_CTRL)) u_dec (
        .opcode_i (opcode_s),
        .funct_i  (id_instr[5:0]),
        .dec_o    (dec_s)
    );

    assign id_ready     = ~ex_stall;
    assign branch_taken = valid_q & br_q & alu_zero & ~ex_stall;

    // Operand muxing and next-state for the EX registers.
    always_comb begin
        imm_ext_s = (dec_s.ext == EXT_SIGN) ? {{(DATA_W-16){imm_s[15]}}, imm_s}
                                            : {{(DATA_W-16){1'b0}}, imm_s};
        case (dec_s.sel0)
            SEL0_RS:      in0_d = id_rs_data;
            SEL0_SHAMT:   in0_d = {{(DATA_W-5){1'b0}}, shamt_s};
            SEL0_SIXTEEN: in0_d = DATA_W'(32'd16);
            default:      in0_d = id_rs_data;
        endcase
        in1_d   = (dec_s.sel1 == SEL1_IMM) ? imm_ext_s : id_rt_data;
        rd_d    = (opcode_s == OP_RTYPE) ? rd_f_s : rt_f_s;
        // A taken branch in EX kills whatever ID offers this cycle.
        load_s  = id_valid & ~flush & ~branch_taken;
        valid_d = load_s;
        wr_d    = load_s & dec_s.reg_write & (rd_d != 5'd0);
        ill_d   = load_s & dec_s.illegal;
        br_d    = load_s & dec_s.is_branch;
        tgt_d   = id_pc4 + {{14{imm_s[15]}}, imm_s, 2'b00};
    end

    // EX pipeline registers; a stall freezes the whole stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= 4'b0000;
            in0_q   <= '0;
            in1_q   <= '0;
            rd_q    <= 5'd0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            br_q    <= 1'b0;
            tgt_q   <= 32'd0;
        end else if (!ex_stall) begin
            ctrl_q  <= dec_s.ctrl;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            br_q    <= br_d;
            tgt_q   <= tgt_d;
        end
    end

    assign alu_ctrl      = ctrl_q;
    assign alu_in_0      = in0_q;
    assign alu_in_1      = in1_q;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = wr_q;
    assign ex_illegal    = ill_q;
    assign branch_target = tgt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue with a behavioural ALU and
// an instruction-level reference model of the issue stage.
module tb_alu_issue;

    logic        clk, rst_n, id_valid, id_ready, ex_stall, flush, alu_zero;
    logic [31:0] id_instr, id_pc4, id_rs_data, id_rt_data;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in_0, alu_in_1, branch_target;
    logic        ex_valid, ex_reg_write, ex_illegal, branch_taken;
    logic [4:0]  ex_rd;

    int total = 0;
    int bad   = 0;

    // Expected EX contents
    logic        m_valid, m_wr, m_ill, m_br;
    logic [3:0]  m_ctrl;
    logic [31:0] m_in0, m_in1, m_tgt;
    logic [4:0]  m_rd;

    alu_issue #(.DATA_W(32), .ILLEGAL_CTRL(4'b1111)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc4(id_pc4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .ex_stall(ex_stall), .flush(flush),
        .alu_ctrl(alu_ctrl), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
        .alu_zero(alu_zero), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] alu_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return ~(a | b);
            4'd9:  return a ^ b;
            4'd10: return b << a[4:0];
            4'd11: return $unsigned($signed(b) >>> a[4:0]);
            4'd12: return b >> a[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic alu_z(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = alu_res(c, a, b);
        return c[2] ? (r == 32'd0) : (r != 32'd0);
    endfunction

    assign alu_zero = alu_z(alu_ctrl, alu_in_0, alu_in_1);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] pc4, output logic [3:0] c, output logic [31:0] a,
                              output logic [31:0] b, output logic [4:0] rd, output logic wr,
                              output logic ill, output logic br, output logic [31:0] tgt);
        logic [31:0] se, ze;
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'd0, ins[15:0]};
        tgt = pc4 + (se << 2);
        ill = 1'b0; br = 1'b0; wr = 1'b1;
        a = rs; b = rt; c = 4'd0; rd = ins[20:16];
        if (ins[31:26] == 6'h00) begin
            rd = ins[15:11];
            case (ins[5:0])
                6'h24: c = 4'd0;
                6'h25: c = 4'd1;
                6'h20, 6'h21: c = 4'd2;
                6'h22, 6'h23: c = 4'd6;
                6'h2A: c = 4'd7;
                6'h27: c = 4'd8;
                6'h26: c = 4'd9;
                6'h00: begin c = 4'd10; a = {27'd0, ins[10:6]}; end
                6'h03: begin c = 4'd11; a = {27'd0, ins[10:6]}; end
                6'h02: begin c = 4'd12; a = {27'd0, ins[10:6]}; end
                6'h04: c = 4'd10;
                6'h07: c = 4'd11;
                6'h06: c = 4'd12;
                default: ill = 1'b1;
            endcase
        end else begin
            case (ins[31:26])
                6'h08, 6'h09, 6'h23: begin c = 4'd2; b = se; end
                6'h2B: begin c = 4'd2; b = se; wr = 1'b0; end
                6'h0A: begin c = 4'd7; b = se; end
                6'h0C: begin c = 4'd0; b = ze; end
                6'h0D: begin c = 4'd1; b = ze; end
                6'h0E: begin c = 4'd9; b = ze; end
                6'h0F: begin c = 4'd10; a = 32'd16; b = ze; end
                6'h04: begin c = 4'd6; wr = 1'b0; br = 1'b1; end
                6'h05: begin c = 4'd3; wr = 1'b0; br = 1'b1; end
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin c = 4'hF; wr = 1'b0; br = 1'b0; end
        if (rd == 5'd0) wr = 1'b0;
    endtask

    function automatic logic exp_bt();
        return m_valid & m_br & alu_z(m_ctrl, m_in0, m_in1) & ~ex_stall;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_wr = 1'b0; m_ill = 1'b0; m_br = 1'b0;
        m_ctrl = 4'd0; m_in0 = 32'd0; m_in1 = 32'd0; m_rd = 5'd0; m_tgt = 32'd0;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                         input logic [31:0] rs, input logic [31:0] rt, input logic st, input logic fl);
        id_valid = v; id_instr = ins; id_pc4 = pc4; id_rs_data = rs; id_rt_data = rt;
        ex_stall = st; flush = fl;
        #1;
        chk("id_ready", {31'd0, id_ready}, {31'd0, ~st});
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, exp_bt()});
    endtask

    task automatic tick();
        logic bt;
        bt = exp_bt();
        if (!ex_stall) begin
            if (flush || bt || !id_valid) begin
                m_valid = 1'b0; m_wr = 1'b0;
            end else begin
                ref_decode(id_instr, id_rs_data, id_rt_data, id_pc4,
                           m_ctrl, m_in0, m_in1, m_rd, m_wr, m_ill, m_br, m_tgt);
                m_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_wr});
        if (m_valid) begin
            chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_ctrl});
            chk("alu_in_0", alu_in_0, m_in0);
            chk("alu_in_1", alu_in_1, m_in1);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, m_ill});
            if (m_br) chk("branch_target", branch_target, m_tgt);
        end
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
        chk({tag, "_in0"}, alu_in_0, 32'd0);
        chk({tag, "_in1"}, alu_in_1, 32'd0);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_rd"}, {27'd0, ex_rd}, 32'd0);
        chk({tag, "_wr"}, {31'd0, ex_reg_write}, 32'd0);
        chk({tag, "_ill"}, {31'd0, ex_illegal}, 32'd0);
        chk({tag, "_tgt"}, branch_target, 32'd0);
        chk({tag, "_bt"}, {31'd0, branch_taken}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] rfn [15] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h27,
                                 6'h26, 6'h00, 6'h03, 6'h02, 6'h04, 6'h07, 6'h06};
        logic [5:0] iop [11] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05};
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 15);
        if (r == 0) return w;
        if (r < 7) return {6'h00, w[25:6], rfn[$urandom_range(0, 14)]};
        return {iop[$urandom_range(0, 10)], w[25:0]};
    endfunction

    localparam logic [31:0] ADD_I  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] SRA_I  = {6'h00, 5'd0, 5'd2, 5'd4, 5'd4, 6'h03};
    localparam logic [31:0] LUI_I  = {6'h0F, 5'd0, 5'd5, 16'h1234};
    localparam logic [31:0] BEQ_I  = {6'h04, 5'd1, 5'd2, 16'hFFFE};
    localparam logic [31:0] BNE_I  = {6'h05, 5'd1, 5'd2, 16'hFFFE};
    localparam logic [31:0] XORI_I = {6'h0E, 5'd1, 5'd6, 16'h00FF};
    localparam logic [31:0] ILL_I  = {6'h3F, 5'd1, 5'd7, 16'h0001};

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_instr = 32'd0; id_pc4 = 32'd0;
        id_rs_data = 32'd0; id_rt_data = 32'd0; ex_stall = 1'b0; flush = 1'b0;
        model_reset();
        #3;
        check_zero_state("rst");
        rst_n = 1'b1;
        #3;

        drive(1'b1, ADD_I, 32'h40, 32'd5, 32'd7, 1'b0, 1'b0); tick();
        chk("add_ctrl", {28'd0, alu_ctrl}, 32'h2);
        chk("add_res", alu_res(alu_ctrl, alu_in_0, alu_in_1), 32'd12);
        chk("add_rd", {27'd0, ex_rd}, 32'd3);

        drive(1'b1, SRA_I, 32'h44, 32'd0, 32'h8000_0000, 1'b0, 1'b0); tick();
        chk("sra_in0", alu_in_0, 32'd4);
        chk("sra_in1", alu_in_1, 32'h8000_0000);

        drive(1'b1, LUI_I, 32'h48, 32'd0, 32'd0, 1'b0, 1'b0); tick();
        chk("lui_res", alu_res(alu_ctrl, alu_in_0, alu_in_1), 32'h1234_0000);

        drive(1'b1, BEQ_I, 32'h100, 32'd9, 32'd9, 1'b0, 1'b0); tick();
        chk("beq_tgt", branch_target, 32'h0000_00F8);
        drive(1'b1, ADD_I, 32'h104, 32'd1, 32'd1, 1'b0, 1'b0);
        chk("beq_taken", {31'd0, branch_taken}, 32'd1);
        tick();
        chk("beq_squash", {31'd0, ex_valid}, 32'd0);

        drive(1'b1, BNE_I, 32'h200, 32'd9, 32'd9, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("bne_not_taken", {31'd0, branch_taken}, 32'd0);
        tick();

        drive(1'b1, XORI_I, 32'h300, 32'h0F0F, 32'd0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADD_I, 32'h304, 32'd1, 32'd2, 1'b1, 1'b0); tick();
            chk("stall_hold_in1", alu_in_1, 32'h0000_00FF);
        end
        drive(1'b1, ADD_I, 32'h304, 32'd1, 32'd2, 1'b1, 1'b1); tick();
        chk("stall_flush_hold", {31'd0, ex_valid}, 32'd1);
        drive(1'b1, ADD_I, 32'h304, 32'd1, 32'd2, 1'b0, 1'b1); tick();
        chk("flush_bubble", {31'd0, ex_valid}, 32'd0);

        drive(1'b1, ILL_I, 32'h400, 32'd1, 32'd2, 1'b0, 1'b0); tick();
        chk("ill_ctrl", {28'd0, alu_ctrl}, 32'hF);
        chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
        chk("ill_wr", {31'd0, ex_reg_write}, 32'd0);

        // Mid-stream reset must clear EX without waiting for a clock edge.
        drive(1'b1, ADD_I, 32'h500, 32'd3, 32'd4, 1'b0, 1'b0); tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero_state("midrst");
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            logic [31:0] rs, rt;
            rs = ($urandom_range(0, 3) == 0) ? {27'd0, 5'($urandom)} : $urandom;
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            drive($urandom_range(0, 5) != 0, rand_instr(), $urandom, rs, rt,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
